// File: rtl/pattern_cap_pkg.sv
// Shared types and constants for the test_final output capture stage.
// Bit indices give the position of each netlist output within pat_out.
package pattern_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam int PAT_W = 11;

    localparam logic [15:0] DEF_POLY = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    localparam int G199_1_R_11_IDX       = 0;
    localparam int G214_1_R_11_IDX       = 1;
    localparam int ACVQN1_2_R_11_IDX     = 2;
    localparam int P6_2_R_11_IDX         = 3;
    localparam int N_429_OR_0_3_R_11_IDX = 4;
    localparam int G78_3_R_11_IDX        = 5;
    localparam int N_576_3_R_11_IDX      = 6;
    localparam int N_102_3_R_11_IDX      = 7;
    localparam int N_547_3_R_11_IDX      = 8;
    localparam int N_42_5_R_11_IDX       = 9;
    localparam int G199_5_R_11_IDX       = 10;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift with parity feedback over the
// POLY taps, XOR in the zero-extended input vector on each enabled cycle.
module misr_core
    import pattern_cap_pkg::*;
#(
    parameter int              WIDTH   = PAT_W,
    parameter int              SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
    parameter logic [SIG_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_reg;
    logic [SIG_W-1:0] sig_next;
    logic [SIG_W-1:0] din_ext;

    generate
        for (genvar gi = 0; gi < SIG_W; gi++) begin : g_ext
            if (gi < WIDTH) begin : g_bit
                assign din_ext[gi] = din[gi];
            end else begin : g_zero
                assign din_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign sig_next = {sig_reg[SIG_W-2:0], ^(sig_reg & POLY)} ^ din_ext;

    // load wins over en; the FSM never asserts both in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_reg <= RST_VAL;
        end else if (load) begin
            sig_reg <= seed;
        end else if (en) begin
            sig_reg <= sig_next;
        end
    end

    assign sig = sig_reg;

endmodule

// File: rtl/pattern_sig_capture.sv
// Capture stage for test_final outputs: settle, compress len samples into a
// MISR, then present the signature under a valid/ack handshake.
module pattern_sig_capture
    import pattern_cap_pkg::*;
#(
    parameter int               WIDTH  = PAT_W,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEF_SEED,
    parameter int               SETTLE = 2
) (
    input  logic             blif_clk_net_1_r_11,
    input  logic             blif_reset_net_1_r_11,
    input  logic [WIDTH-1:0] pat_out,
    input  logic             start,
    input  logic [7:0]       len,
    output logic             busy,
    output logic             cap_en,
    output logic [SIG_W-1:0] sig,
    output logic             sig_valid,
    input  logic             sig_ack,
    output logic             len_err
);

    localparam int              SCW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SCW-1:0]  SETTLE_LD = SCW'(SETTLE);

    cap_state_t     state_reg;
    logic [7:0]     cap_cnt_reg;
    logic [SCW-1:0] settle_cnt_reg;
    logic           busy_reg;
    logic           cap_en_reg;
    logic           sig_valid_reg;
    logic           len_err_reg;

    logic misr_load;
    logic misr_en;

    assign misr_load = (state_reg == ST_IDLE) && start && (len != 8'd0);
    assign misr_en   = (state_reg == ST_CAPTURE);

    misr_core #(
        .WIDTH   (WIDTH),
        .SIG_W   (SIG_W),
        .POLY    (POLY),
        .RST_VAL (SEED)
    ) u_misr (
        .clk   (blif_clk_net_1_r_11),
        .rst_n (blif_reset_net_1_r_11),
        .load  (misr_load),
        .seed  (SEED),
        .en    (misr_en),
        .din   (pat_out),
        .sig   (sig)
    );

    // Outputs are set on the transition into each state so they are
    // registered copies of the state the FSM is about to occupy.
    always_ff @(posedge blif_clk_net_1_r_11 or negedge blif_reset_net_1_r_11) begin
        if (!blif_reset_net_1_r_11) begin
            state_reg      <= ST_IDLE;
            cap_cnt_reg    <= 8'd0;
            settle_cnt_reg <= '0;
            busy_reg       <= 1'b0;
            cap_en_reg     <= 1'b0;
            sig_valid_reg  <= 1'b0;
            len_err_reg    <= 1'b0;
        end else begin
            len_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (len == 8'd0) begin
                            len_err_reg <= 1'b1;
                        end else begin
                            cap_cnt_reg <= len;
                            busy_reg    <= 1'b1;
                            if (SETTLE == 0) begin
                                state_reg  <= ST_CAPTURE;
                                cap_en_reg <= 1'b1;
                            end else begin
                                state_reg      <= ST_SETTLE;
                                settle_cnt_reg <= SETTLE_LD;
                            end
                        end
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg - SCW'(1);
                    if (settle_cnt_reg == SCW'(1)) begin
                        state_reg  <= ST_CAPTURE;
                        cap_en_reg <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // the MISR absorbs on this edge; the last one moves to DONE
                    cap_cnt_reg <= cap_cnt_reg - 8'd1;
                    if (cap_cnt_reg == 8'd1) begin
                        state_reg     <= ST_DONE;
                        cap_en_reg    <= 1'b0;
                        busy_reg      <= 1'b0;
                        sig_valid_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (sig_ack) begin
                        state_reg     <= ST_IDLE;
                        sig_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign cap_en    = cap_en_reg;
    assign sig_valid = sig_valid_reg;
    assign len_err   = len_err_reg;

endmodule

// File: tb/tb_pattern_sig_capture.sv
// Randomized scoreboard bench for pattern_sig_capture with a queue-based
// signature model and a decoupled monitor on the valid handshake.
module tb_pattern_sig_capture;

    localparam int          SETTLE_C = 2;
    localparam logic [15:0] POLY_C   = 16'hB400;
    localparam logic [15:0] SEED_C   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] pat_out = '0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        cap_en;
    logic [15:0] sig;
    logic        sig_valid;
    logic        sig_ack = 1'b0;
    logic        len_err;

    typedef struct {
        logic [15:0] sig;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_sig = SEED_C;

    pattern_sig_capture #(
        .WIDTH  (11),
        .SIG_W  (16),
        .POLY   (POLY_C),
        .SEED   (SEED_C),
        .SETTLE (SETTLE_C)
    ) dut (
        .blif_clk_net_1_r_11   (clk),
        .blif_reset_net_1_r_11 (rst_n),
        .pat_out               (pat_out),
        .start                 (start),
        .len                   (len),
        .busy                  (busy),
        .cap_en                (cap_en),
        .sig                   (sig),
        .sig_valid             (sig_valid),
        .sig_ack               (sig_ack),
        .len_err               (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference signature: integer shift/parity arithmetic over the sample list.
    function automatic logic [15:0] model(input logic [15:0] seed, input logic [10:0] smp[$]);
        int s;
        int fb;
        s = int'(seed);
        foreach (smp[i]) begin
            fb = $countones(s & int'(POLY_C)) % 2;
            s  = ((s * 2) % 65536) + fb;
            s  = s ^ int'(smp[i]);
        end
        return 16'(s);
    endfunction

    // Monitor: on each sig_valid rise, pop and compare signature and counts.
    initial begin
        int   cap_cnt_m;
        int   busy_cnt_m;
        logic prev_v;
        exp_t e;
        cap_cnt_m  = 0;
        busy_cnt_m = 0;
        prev_v     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cap_cnt_m  = 0;
                busy_cnt_m = 0;
                prev_v     = 1'b0;
            end else begin
                if (cap_en) cap_cnt_m++;
                if (busy)   busy_cnt_m++;
                if (sig_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid: got sig %0h expected no transaction", sig);
                    end else begin
                        e = sb.pop_front();
                        check("sb_sig", 32'(sig), 32'(e.sig));
                        check("sb_cap_cycles", 32'(cap_cnt_m), 32'(e.len));
                        check("sb_busy_cycles", 32'(busy_cnt_m), 32'(SETTLE_C + e.len));
                        $display("txn len=%0d sig=%04h exp=%04h", e.len, sig, e.sig);
                    end
                    cap_cnt_m  = 0;
                    busy_cnt_m = 0;
                end
                prev_v = sig_valid;
            end
        end
    end

    // Called at a negedge; the start is accepted at the following posedge.
    task automatic do_run(input logic [10:0] smp[$], input int hold, input bit spam, input bit ack_early);
        exp_t e;
        int   n;
        n     = smp.size();
        e.sig = model(SEED_C, smp);
        e.len = n;
        sb.push_back(e);
        start   = 1'b1;
        len     = 8'(n);
        pat_out = 11'($urandom);
        for (int k = 1; k <= SETTLE_C + n; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (spam && n >= 3 && k == SETTLE_C + 2) begin
                start = 1'b1;
                len   = 8'($urandom_range(1, 255));
            end
            if (ack_early && k == SETTLE_C + n) sig_ack = 1'b1;
            pat_out = (k <= SETTLE_C) ? 11'($urandom) : smp[k - SETTLE_C - 1];
            check("run_busy", 32'(busy), 32'd1);
            check("run_cap_en", 32'(cap_en), 32'(k > SETTLE_C));
            check("run_valid_low", 32'(sig_valid), 32'd0);
        end
        @(negedge clk);
        start   = 1'b0;
        pat_out = 11'($urandom);
        check("valid_rise", 32'(sig_valid), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        for (int h = 0; h < hold; h++) begin
            check("done_hold_sig", 32'(sig), 32'(e.sig));
            check("done_hold_valid", 32'(sig_valid), 32'd1);
            @(negedge clk);
            pat_out = 11'($urandom);
        end
        sig_ack = 1'b1;
        @(negedge clk);
        sig_ack = 1'b0;
        check("ack_valid_low", 32'(sig_valid), 32'd0);
        check("idle_sig_held", 32'(sig), 32'(e.sig));
        last_sig = e.sig;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] q[$];

        // reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cap_en", 32'(cap_en), 32'd0);
        check("rst_valid", 32'(sig_valid), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_sig", 32'(sig), 32'(SEED_C));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed: single sample of 1, then 1 followed by 2
        q = {11'h001};
        do_run(q, 0, 1'b0, 1'b0);
        check("dir_len1_sig", 32'(last_sig), 32'h0001);
        q = {11'h001, 11'h002};
        do_run(q, 0, 1'b0, 1'b0);

        // len=0 start is rejected with one len_err pulse
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("lenerr_pulse", 32'(len_err), 32'd1);
        check("lenerr_busy", 32'(busy), 32'd0);
        check("lenerr_sig", 32'(sig), 32'(last_sig));
        @(negedge clk);
        check("lenerr_single", 32'(len_err), 32'd0);
        check("lenerr_idle_valid", 32'(sig_valid), 32'd0);

        // randomized runs, some with a stray start during capture
        for (int r = 0; r < 8; r++) begin
            int n;
            q.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) q.push_back(11'($urandom));
            do_run(q, $urandom_range(0, 4), r[0], 1'b0);
        end

        // DONE held for 10 cycles, then ack coinciding with DONE entry
        q.delete();
        for (int i = 0; i < 7; i++) q.push_back(11'($urandom));
        do_run(q, 10, 1'b1, 1'b0);
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(11'($urandom));
        do_run(q, 0, 1'b0, 1'b1);

        // asynchronous reset in the middle of a capture
        start   = 1'b1;
        len     = 8'd20;
        pat_out = 11'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE_C + 4) begin
            @(negedge clk);
            pat_out = 11'($urandom);
        end
        check("pre_rst_cap_en", 32'(cap_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cap_en", 32'(cap_en), 32'd0);
        check("arst_valid", 32'(sig_valid), 32'd0);
        check("arst_sig", 32'(sig), 32'(SEED_C));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q = {11'h001, 11'h002};
        do_run(q, 1, 1'b0, 1'b0);

        // long run of zero samples
        q.delete();
        for (int i = 0; i < 255; i++) q.push_back(11'h000);
        do_run(q, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
